// File: rtl/dmem_responder_pkg.sv
// Shared constants, request payload and lane-merge helper for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned DEPTH_WORDS_DEFAULT = 4096;
  localparam logic [31:0] MMIO_BASE_DEFAULT   = 32'hFFFF_0000;

  localparam logic [7:0] OFF_MTIME_LO    = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI    = 8'h04;
  localparam logic [7:0] OFF_MTIMECMP_LO = 8'h08;
  localparam logic [7:0] OFF_MTIMECMP_HI = 8'h0C;
  localparam logic [7:0] OFF_GPIO        = 8'h10;
  localparam logic [7:0] OFF_STATUS      = 8'h14;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_MMIO,
    RGN_NONE
  } region_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  lanes;
    logic [31:0] wdata;
  } dmem_req_t;

  // Replace the enabled byte lanes of old_word with those of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_mmio_timer.sv
// 64-bit machine timer with compare register, byte-lane writes and compare interrupt.
module dmem_mmio_timer
  import dmem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_lo,
  input  logic        sel_hi,
  input  logic        sel_cmp_lo,
  input  logic        sel_cmp_hi,
  input  logic [3:0]  lanes,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        timer_irq
);

  logic [63:0] mtime_inc;
  logic [63:0] mtime_nxt;
  logic [63:0] cmp_nxt;

  // Unwritten lanes keep counting; a LO write holds HI so no carry leaks into it.
  always_comb begin
    mtime_inc = mtime + 64'd1;
    mtime_nxt = mtime_inc;
    cmp_nxt   = mtimecmp;
    if (sel_lo) begin
      mtime_nxt[31:0]  = merge_lanes(mtime_inc[31:0], wdata, lanes);
      mtime_nxt[63:32] = mtime[63:32];
    end
    if (sel_hi)     mtime_nxt[63:32] = merge_lanes(mtime_inc[63:32], wdata, lanes);
    if (sel_cmp_lo) cmp_nxt[31:0]    = merge_lanes(mtimecmp[31:0], wdata, lanes);
    if (sel_cmp_hi) cmp_nxt[63:32]   = merge_lanes(mtimecmp[63:32], wdata, lanes);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime_nxt;
      mtimecmp  <= cmp_nxt;
      timer_irq <= (mtime_nxt >= cmp_nxt);
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-port target for the core: byte-writable synchronous RAM plus timer/GPIO/status MMIO window.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [3:0]  datamem_wr,
  input  logic [7:0]  data_wr0,
  input  logic [7:0]  data_wr1,
  input  logic [7:0]  data_wr2,
  input  logic [7:0]  data_wr3,
  output logic [31:0] data_rd,
  output logic [31:0] gpio_out,
  output logic        timer_irq,
  output logic        bus_err
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  dmem_req_t   req;
  region_e     region;
  logic [7:0]  off;
  logic        wr_any;
  logic        mmio_wr;
  logic        off_valid;
  logic        err_set;
  logic        err_clr;
  logic        err_q;
  logic [AW-1:0] ram_idx;
  logic [31:0] mmio_rdata;
  logic [31:0] rd_nxt;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        unused_addr_bits;

  logic [31:0] mem [DEPTH_WORDS];

  // Request capture and address decode; RAM takes priority over an overlapping window.
  always_comb begin
    req.addr  = data_addr;
    req.lanes = datamem_wr;
    req.wdata = {data_wr3, data_wr2, data_wr1, data_wr0};
    if ({1'b0, req.addr} < RAM_BYTES)             region = RGN_RAM;
    else if (req.addr[31:8] == MMIO_BASE[31:8])   region = RGN_MMIO;
    else                                          region = RGN_NONE;
    off     = {req.addr[7:2], 2'b00};
    ram_idx = req.addr[AW+1:2];
    wr_any  = |req.lanes;
    mmio_wr = (region == RGN_MMIO) && wr_any;
  end

  assign unused_addr_bits = ^req.addr[1:0];

  always_comb begin
    mmio_rdata = '0;
    off_valid  = 1'b1;
    case (off)
      OFF_MTIME_LO:    mmio_rdata = mtime[31:0];
      OFF_MTIME_HI:    mmio_rdata = mtime[63:32];
      OFF_MTIMECMP_LO: mmio_rdata = mtimecmp[31:0];
      OFF_MTIMECMP_HI: mmio_rdata = mtimecmp[63:32];
      OFF_GPIO:        mmio_rdata = gpio_out;
      OFF_STATUS:      mmio_rdata = {31'd0, err_q};
      default:         off_valid  = 1'b0;
    endcase
  end

  always_comb begin
    err_set = (region == RGN_NONE) || ((region == RGN_MMIO) && !off_valid);
    err_clr = mmio_wr && (off == OFF_STATUS) && req.lanes[0] && req.wdata[0];
    case (region)
      RGN_RAM:  rd_nxt = mem[ram_idx];
      RGN_MMIO: rd_nxt = mmio_rdata;
      default:  rd_nxt = '0;
    endcase
  end

  // Per-byte write enables; writes presented alongside reset are dropped.
  always_ff @(posedge clk) begin
    if (!rst && (region == RGN_RAM)) begin
      for (int i = 0; i < 4; i++) begin
        if (req.lanes[i]) mem[ram_idx][8*i +: 8] <= req.wdata[8*i +: 8];
      end
    end
  end

  // Read data, GPIO and sticky error; a fresh error outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_rd  <= '0;
      gpio_out <= '0;
      err_q    <= 1'b0;
    end else begin
      data_rd <= rd_nxt;
      if (mmio_wr && (off == OFF_GPIO)) gpio_out <= merge_lanes(gpio_out, req.wdata, req.lanes);
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  assign bus_err = err_q;

  dmem_mmio_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .sel_lo     (mmio_wr && (off == OFF_MTIME_LO)),
    .sel_hi     (mmio_wr && (off == OFF_MTIME_HI)),
    .sel_cmp_lo (mmio_wr && (off == OFF_MTIMECMP_LO)),
    .sel_cmp_hi (mmio_wr && (off == OFF_MTIMECMP_HI)),
    .lanes      (req.lanes),
    .wdata      (req.wdata),
    .mtime      (mtime),
    .mtimecmp   (mtimecmp),
    .timer_irq  (timer_irq)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: RAM lanes, read-first, MMIO timer, GPIO, status, reset.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam logic [31:0] MM       = MMIO_BASE_DEFAULT;
  localparam logic [31:0] A_MT_LO  = MM + 32'(OFF_MTIME_LO);
  localparam logic [31:0] A_MT_HI  = MM + 32'(OFF_MTIME_HI);
  localparam logic [31:0] A_CMP_LO = MM + 32'(OFF_MTIMECMP_LO);
  localparam logic [31:0] A_CMP_HI = MM + 32'(OFF_MTIMECMP_HI);
  localparam logic [31:0] A_GPIO   = MM + 32'(OFF_GPIO);
  localparam logic [31:0] A_STATUS = MM + 32'(OFF_STATUS);
  localparam logic [31:0] A_UNDEF  = MM + 32'h18;
  localparam logic [31:0] A_UNMAP  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr;
  logic [3:0]  datamem_wr;
  logic [7:0]  data_wr0, data_wr1, data_wr2, data_wr3;
  logic [31:0] data_rd;
  logic [31:0] gpio_out;
  logic        timer_irq;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .data_addr  (data_addr),
    .datamem_wr (datamem_wr),
    .data_wr0   (data_wr0),
    .data_wr1   (data_wr1),
    .data_wr2   (data_wr2),
    .data_wr3   (data_wr3),
    .data_rd    (data_rd),
    .gpio_out   (gpio_out),
    .timer_irq  (timer_irq),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: present the access, take the edge, settle past it.
  task automatic cyc(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    data_addr  = a;
    datamem_wr = m;
    {data_wr3, data_wr2, data_wr1, data_wr0} = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    data_addr = '0; datamem_wr = '0;
    data_wr0 = '0; data_wr1 = '0; data_wr2 = '0; data_wr3 = '0;
    idle(2);
    check("rst_data_rd", data_rd, 0);
    check("rst_gpio", gpio_out, 0);
    check("rst_irq", timer_irq, 0);
    check("rst_bus_err", bus_err, 0);
    rst = 1'b0;

    // RAM byte lanes
    cyc(32'h100, 4'hF, 32'hAABB_CCDD);
    cyc(32'h100, 4'b0010, 32'hFFFF_11FF);
    cyc(32'h100, 4'h0, 32'h0);
    check("ram_byte_lane", data_rd, 32'hAABB_11DD);

    // Read-first on same word
    cyc(32'h40, 4'hF, 32'h0);
    cyc(32'h40, 4'hF, 32'h5555_5555);
    check("read_first_old", data_rd, 32'h0);
    cyc(32'h40, 4'h0, 32'h0);
    check("read_first_new", data_rd, 32'h5555_5555);

    // GPIO with lanes
    cyc(A_GPIO, 4'hF, 32'h1234_5678);
    check("gpio_full", gpio_out, 32'h1234_5678);
    cyc(A_GPIO, 4'b0100, 32'h00AA_0000);
    check("gpio_lane2", gpio_out, 32'h12AA_5678);

    // Unmapped access and status W1C
    cyc(32'h0, 4'hF, 32'h0102_0304);
    check("no_err_mapped", bus_err, 0);
    cyc(A_UNMAP, 4'hF, 32'hFFFF_FFFF);
    check("unmap_rd_zero", data_rd, 0);
    check("unmap_err", bus_err, 1);
    cyc(32'h0, 4'h0, 32'h0);
    check("unmap_no_ram_write", data_rd, 32'h0102_0304);
    cyc(A_STATUS, 4'h0, 32'h0);
    check("status_read", data_rd, 1);
    cyc(A_STATUS, 4'hF, 32'h0);
    check("w1c_zero_keeps", bus_err, 1);
    cyc(A_STATUS, 4'b1110, 32'hFFFF_FFFF);
    check("w1c_lane_off_keeps", bus_err, 1);
    cyc(A_STATUS, 4'b0001, 32'h1);
    check("w1c_clears", bus_err, 0);
    cyc(A_UNDEF, 4'h0, 32'h0);
    check("undef_off_rd", data_rd, 0);
    check("undef_off_err", bus_err, 1);
    cyc(A_STATUS, 4'b0001, 32'h1);
    check("w1c_clears2", bus_err, 0);

    // Timer compare: mtime = k after k edges following the reset edge
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("tmr_rst_irq", timer_irq, 0);
    cyc(A_CMP_HI, 4'hF, 32'h0);
    cyc(A_CMP_LO, 4'hF, 32'd20);
    idle(17);
    check("irq_before_cmp", timer_irq, 0);
    idle(1);
    check("irq_at_cmp", timer_irq, 1);
    cyc(A_MT_LO, 4'h0, 32'h0);
    check("mtime_readback", data_rd, 32'd20);
    cyc(A_CMP_LO, 4'hF, 32'hFFFF_FFFF);
    check("irq_falls", timer_irq, 0);
    cyc(A_CMP_HI, 4'hF, 32'hFFFF_FFFF);
    check("irq_stays_low", timer_irq, 0);

    // Carry suppression on LO write
    cyc(A_MT_LO, 4'hF, 32'hFFFF_FFF0);
    idle(15);
    cyc(A_MT_LO, 4'hF, 32'd5);
    cyc(A_MT_LO, 4'h0, 32'h0);
    check("carry_sup_lo", data_rd, 32'd5);
    cyc(A_MT_HI, 4'h0, 32'h0);
    check("carry_sup_hi", data_rd, 32'd0);

    // Ordinary carry into HI
    cyc(A_MT_LO, 4'hF, 32'hFFFF_FFFF);
    cyc(A_MT_HI, 4'h0, 32'h0);
    check("carry_pre", data_rd, 32'd0);
    cyc(A_MT_HI, 4'h0, 32'h0);
    check("carry_hi", data_rd, 32'd1);
    cyc(A_MT_LO, 4'b0001, 32'h0000_00AB);
    cyc(A_MT_LO, 4'h0, 32'h0);
    check("mtime_lane0", data_rd, 32'h0000_00AB);

    // Wrap from all-ones; compare is all-ones here
    cyc(A_MT_HI, 4'hF, 32'hFFFF_FFFF);
    cyc(A_MT_LO, 4'hF, 32'hFFFF_FFFF);
    check("irq_all_ones", timer_irq, 1);
    cyc(A_MT_HI, 4'h0, 32'h0);
    check("wrap_hi_before", data_rd, 32'hFFFF_FFFF);
    check("irq_after_wrap", timer_irq, 0);
    cyc(A_MT_HI, 4'h0, 32'h0);
    check("wrap_hi_after", data_rd, 32'h0);
    cyc(A_MT_LO, 4'h0, 32'h0);
    check("wrap_lo_after", data_rd, 32'd1);

    // Reset mid-stream with a pending GPIO write
    cyc(A_UNMAP, 4'h0, 32'h0);
    check("pre_rst_err", bus_err, 1);
    rst = 1'b1;
    cyc(A_GPIO, 4'hF, 32'h0000_1234);
    rst = 1'b0;
    check("midrst_gpio", gpio_out, 0);
    check("midrst_rd", data_rd, 0);
    check("midrst_err", bus_err, 0);
    check("midrst_irq", timer_irq, 0);
    cyc(A_MT_LO, 4'h0, 32'h0);
    check("midrst_mtime", data_rd, 0);

    // RAM write presented with reset is dropped
    cyc(32'h200, 4'hF, 32'h1111_1111);
    rst = 1'b1;
    cyc(32'h200, 4'hF, 32'h2222_2222);
    rst = 1'b0;
    cyc(32'h200, 4'h0, 32'h0);
    check("rst_drops_ram_wr", data_rd, 32'h1111_1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
